scr1_tb_ahb_mmio: RTL

SCR1_TB_AHB_MMIO -- requirements
Module: scr1_tb_ahb_mmio

---
 rtl/scr1_tb_ahb_mmio.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/scr1_tb_ahb_mmio.sv
// AHB-Lite MMIO slave for the testbench: test status, console, 64-bit machine timer,
// software-driven IRQ lines and software interrupt, with a pattern-driven wait-state generator.
module scr1_tb_ahb_mmio (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic        hready,
  output logic [31:0] hrdata,
  output logic        hresp,
  input  logic [31:0] stall_pattern_in,
  output logic        test_done,
  output logic        test_pass,
  output logic [31:0] test_code,
  output logic        con_vld,
  output logic [7:0]  con_data,
  output logic [7:0]  irq_lines,
  output logic        timer_irq,
  output logic        soft_irq
);

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

  localparam logic [5:0] W_STATUS  = 6'd0;
  localparam logic [5:0] W_CONSOLE = 6'd1;
  localparam logic [5:0] W_MTLO    = 6'd2;
  localparam logic [5:0] W_MTHI    = 6'd3;
  localparam logic [5:0] W_CMPLO   = 6'd4;
  localparam logic [5:0] W_CMPHI   = 6'd5;
  localparam logic [5:0] W_IRQSET  = 6'd6;
  localparam logic [5:0] W_IRQCLR  = 6'd7;
  localparam logic [5:0] W_SOFT    = 6'd8;

  state_t      state, state_next;
  logic [4:0]  rot;
  logic [5:0]  addr_q;
  logic        wr_q;
  logic        accept, legal, complete, wr_en;
  logic [31:0] rd_data;
  logic [63:0] mtime, mtimecmp;
  logic [31:0] mtime_shadow;
  logic        unused_bits;

  assign unused_bits = ^{htrans[0], haddr[31:8]};

  // Only word-sized, word-aligned accesses to the nine mapped registers are legal.
  assign legal = (hsize == 3'b010) && (haddr[1:0] == 2'b00) && (haddr[7:2] <= W_SOFT);

  always_comb begin
    state_next = state;
    hready     = 1'b1;
    hresp      = 1'b0;
    hrdata     = '0;
    case (state)
      DATA:    hready = stall_pattern_in[rot];
      ERR1:    begin hready = 1'b0; hresp = 1'b1; end
      ERR2:    hresp = 1'b1;
      default: ;
    endcase
    accept   = hsel && htrans[1] && hready;
    complete = (state == DATA) && hready;
    wr_en    = complete && wr_q;
    if (complete && !wr_q) hrdata = rd_data;
    case (state)
      IDLE, ERR2: state_next = accept ? (legal ? DATA : ERR1) : IDLE;
      DATA:       if (hready) state_next = accept ? (legal ? DATA : ERR1) : IDLE;
      ERR1:       state_next = ERR2;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (addr_q)
      W_STATUS:          rd_data = test_code;
      W_MTLO:            rd_data = mtime[31:0];
      W_MTHI:            rd_data = mtime_shadow;
      W_CMPLO:           rd_data = mtimecmp[31:0];
      W_CMPHI:           rd_data = mtimecmp[63:32];
      W_IRQSET, W_IRQCLR: rd_data = {24'd0, irq_lines};
      W_SOFT:            rd_data = {31'd0, soft_irq};
      default:           rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rot          <= '0;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      test_done    <= 1'b0;
      test_pass    <= 1'b0;
      test_code    <= '0;
      con_vld      <= 1'b0;
      con_data     <= '0;
      mtime        <= '0;
      mtime_shadow <= '0;
      mtimecmp     <= '1;
      timer_irq    <= 1'b0;
      irq_lines    <= '0;
      soft_irq     <= 1'b0;
    end else begin
      state     <= state_next;
      con_vld   <= 1'b0;
      timer_irq <= (mtime >= mtimecmp);
      mtime     <= mtime + 64'd1;
      if (accept) begin
        addr_q <= haddr[7:2];
        wr_q   <= hwrite;
      end
      if (state == DATA) rot <= rot + 5'd1;
      // Reading the low half snapshots the high half so a LO-then-HI read pair is atomic.
      if (complete && !wr_q && addr_q == W_MTLO) mtime_shadow <= mtime[63:32];
      if (wr_en) begin
        case (addr_q)
          W_STATUS: begin
            test_code <= hwdata;
            test_pass <= (hwdata == 32'd0);
            test_done <= 1'b1;
          end
          W_CONSOLE: begin
            con_vld  <= 1'b1;
            con_data <= hwdata[7:0];
          end
          W_MTLO:   mtime <= {mtime[63:32], hwdata};
          W_MTHI:   mtime <= {hwdata, mtime[31:0]};
          W_CMPLO:  mtimecmp[31:0]  <= hwdata;
          W_CMPHI:  mtimecmp[63:32] <= hwdata;
          W_IRQSET: irq_lines <= irq_lines | hwdata[7:0];
          W_IRQCLR: irq_lines <= irq_lines & ~hwdata[7:0];
          W_SOFT:   soft_irq  <= hwdata[0];
          default:  ;
        endcase
      end
    end
  end

endmodule
